// File: rtl/step_delay_sequencer_if.sv
// -----------------------------------------------------------------------------
// step_delay_sequencer_if
// Bundles the control, configuration and status signals of the step delay
// sequencer.
//   master : drives start/trigger/abort and the delay-table write port,
//            observes busy/step_idx/step_pulse/done/timeout_err
//   slave  : the sequencer itself
// Parameters: NUM_STEPS (steps per sequence), W (delay/counter width).
// -----------------------------------------------------------------------------
interface step_delay_sequencer_if #(
    parameter int NUM_STEPS = 4,
    parameter int W         = 32
);
    localparam int IW = $clog2(NUM_STEPS);

    logic          start;
    logic          trigger;
    logic          abort;
    logic          cfg_we;
    logic [IW-1:0] cfg_addr;
    logic [W-1:0]  cfg_delay;
    logic          busy;
    logic [IW-1:0] step_idx;
    logic          step_pulse;
    logic          done;
    logic          timeout_err;

    modport master (
        output start, trigger, abort, cfg_we, cfg_addr, cfg_delay,
        input  busy, step_idx, step_pulse, done, timeout_err
    );

    modport slave (
        input  start, trigger, abort, cfg_we, cfg_addr, cfg_delay,
        output busy, step_idx, step_pulse, done, timeout_err
    );
endinterface

// File: rtl/step_delay_sequencer.sv
// -----------------------------------------------------------------------------
// step_delay_sequencer
// Multi-step timed sequencer. Each step arms, waits for a trigger, counts a
// programmable per-step delay from that trigger and emits a one-cycle
// step_pulse. After NUM_STEPS steps it pulses done and returns to IDLE.
// An armed step that sees no trigger within TIMEOUT cycles pulses
// timeout_err and aborts the sequence (TIMEOUT = 0 disables the watchdog).
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset (also restores the delay table to 1)
//   bus  : step_delay_sequencer_if.slave
//          start, trigger, abort, cfg_we/cfg_addr/cfg_delay  (inputs)
//          busy, step_idx, step_pulse, done, timeout_err       (outputs)
// -----------------------------------------------------------------------------
module step_delay_sequencer #(
    parameter int NUM_STEPS = 4,
    parameter int W         = 32,
    parameter int TIMEOUT   = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    step_delay_sequencer_if.slave bus
);
    localparam int             IW       = $clog2(NUM_STEPS);
    localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_STEPS - 1);
    localparam logic [W-1:0]   TO_LAST  = (TIMEOUT == 0) ? '0 : W'(TIMEOUT - 1);
    localparam logic [W-1:0]   CNT_MAX  = '1;
    localparam logic [W-1:0]   ONE      = W'(1);

    typedef enum logic [1:0] {IDLE, ARMED, DELAY} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic [W-1:0]  tcnt, tcnt_nxt;
    logic [W-1:0]  dcnt, dcnt_nxt;
    logic [W-1:0]  delay_tbl [NUM_STEPS];
    logic [W-1:0]  cur_delay;
    logic          pulse_hit;
    logic          timeout_hit;

    // A stored delay of 0 behaves as 1: the pulse can never precede the
    // cycle after its trigger.
    function automatic logic [W-1:0] eff_delay(input logic [W-1:0] v);
        return (v == '0) ? ONE : v;
    endfunction

    // Counters hold at all-ones instead of wrapping.
    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (v == CNT_MAX) ? v : v + ONE;
    endfunction

    // Delay table: writable only while idle, so a running sequence always
    // sees a stable table.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                delay_tbl[i] <= ONE;
            end
        end else if (state == IDLE && bus.cfg_we && int'(bus.cfg_addr) < NUM_STEPS) begin
            delay_tbl[bus.cfg_addr] <= bus.cfg_delay;
        end
    end

    assign cur_delay   = eff_delay(delay_tbl[idx]);
    assign pulse_hit   = (state == DELAY) && (dcnt == cur_delay);
    // A trigger in the last watchdog cycle wins over the timeout.
    assign timeout_hit = (TIMEOUT != 0) && (state == ARMED) && !bus.trigger
                         && (tcnt == TO_LAST);

    // Event outputs are decoded straight from registered state; abort masks them.
    assign bus.busy        = (state != IDLE);
    assign bus.step_idx    = idx;
    assign bus.step_pulse  = pulse_hit && !bus.abort;
    assign bus.done        = pulse_hit && !bus.abort && (idx == LAST_IDX);
    assign bus.timeout_err = timeout_hit && !bus.abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            tcnt  <= '0;
            dcnt  <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            tcnt  <= tcnt_nxt;
            dcnt  <= dcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        tcnt_nxt  = tcnt;
        dcnt_nxt  = dcnt;
        if (bus.abort) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            tcnt_nxt  = '0;
            dcnt_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state_nxt = ARMED;
                        idx_nxt   = '0;
                        tcnt_nxt  = '0;
                        dcnt_nxt  = '0;
                    end
                end
                ARMED: begin
                    if (bus.trigger) begin
                        // The trigger cycle itself counts as delay cycle 0.
                        state_nxt = DELAY;
                        dcnt_nxt  = ONE;
                        tcnt_nxt  = '0;
                    end else if (timeout_hit) begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                        tcnt_nxt  = '0;
                    end else begin
                        tcnt_nxt = sat_inc(tcnt);
                    end
                end
                DELAY: begin
                    if (pulse_hit) begin
                        dcnt_nxt = '0;
                        if (idx == LAST_IDX) begin
                            state_nxt = IDLE;
                            idx_nxt   = '0;
                        end else begin
                            state_nxt = ARMED;
                            idx_nxt   = idx + 1'b1;
                            tcnt_nxt  = '0;
                        end
                    end else begin
                        dcnt_nxt = sat_inc(dcnt);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                    tcnt_nxt  = '0;
                    dcnt_nxt  = '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_step_delay_sequencer.sv
// -----------------------------------------------------------------------------
// tb_step_delay_sequencer
// Directed scenarios followed by a randomized run. Every cycle the DUT
// outputs are compared against an event-time reference model: the model
// remembers when the current step was armed and the absolute cycle at which
// its pulse is due, and derives expected outputs from those times.
// -----------------------------------------------------------------------------
module tb_step_delay_sequencer;
    localparam int NS = 4;
    localparam int W  = 16;
    localparam int TO = 8;
    localparam int IW = $clog2(NS);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    step_delay_sequencer_if #(.NUM_STEPS(NS), .W(W)) bus ();

    step_delay_sequencer #(.NUM_STEPS(NS), .W(W), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int t0     = 0;

    // reference model state
    int m_tbl [NS];
    bit m_busy;
    int m_idx;
    int m_arm_t;
    int m_fire_t;

    // observed values of the last cycle, and event times relative to t0
    logic o_busy, o_pulse, o_done, o_to;
    int   pq[$];
    int   dq[$];
    int   tq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) m_tbl[i] = 1;
        m_busy   = 0;
        m_idx    = 0;
        m_arm_t  = 0;
        m_fire_t = -1;
    endtask

    task automatic do_reset(input int n);
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.trigger   = 1'b0;
        bus.abort     = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_delay = '0;
        repeat (n) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic do_cycle(input bit s, input bit tg, input bit ab,
                            input bit we, input int ad, input int dl);
        bit e_pulse, e_done, e_to;
        bus.start     = s;
        bus.trigger   = tg;
        bus.abort     = ab;
        bus.cfg_we    = we;
        bus.cfg_addr  = IW'(ad);
        bus.cfg_delay = W'(dl);
        @(negedge clk);
        e_pulse = 0;
        e_done  = 0;
        e_to    = 0;
        if (m_busy && !ab) begin
            if (m_fire_t < 0) begin
                if (!tg && (cyc - m_arm_t) == TO - 1) e_to = 1;
            end else if (cyc == m_fire_t) begin
                e_pulse = 1;
                e_done  = (m_idx == NS - 1);
            end
        end
        o_busy  = bus.busy;
        o_pulse = bus.step_pulse;
        o_done  = bus.done;
        o_to    = bus.timeout_err;
        chk("busy",        32'(o_busy),       32'(m_busy));
        chk("step_idx",    32'(bus.step_idx), m_busy ? m_idx : 0);
        chk("step_pulse",  32'(o_pulse),      32'(e_pulse));
        chk("done",        32'(o_done),       32'(e_done));
        chk("timeout_err", 32'(o_to),         32'(e_to));
        if (o_pulse === 1'b1) pq.push_back(cyc - t0);
        if (o_done  === 1'b1) dq.push_back(cyc - t0);
        if (o_to    === 1'b1) tq.push_back(cyc - t0);
        // advance the model to the next cycle
        if (!m_busy && we) m_tbl[ad] = dl;
        if (ab) begin
            m_busy = 0;
        end else if (!m_busy) begin
            if (s) begin
                m_busy   = 1;
                m_idx    = 0;
                m_arm_t  = cyc + 1;
                m_fire_t = -1;
            end
        end else if (m_fire_t < 0) begin
            if (tg) m_fire_t = cyc + eff(m_tbl[m_idx]);
            else if (e_to) m_busy = 0;
        end else if (e_pulse) begin
            if (e_done) m_busy = 0;
            else begin
                m_idx++;
                m_arm_t  = cyc + 1;
                m_fire_t = -1;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic clear_q();
        pq.delete();
        dq.delete();
        tq.delete();
    endtask

    initial begin
        int e1[4];
        e1 = '{4, 9, 15, 22};
        model_reset();
        do_reset(3);

        // reset state
        do_cycle(0, 0, 0, 0, 0, 0);
        chk("rst_busy", 32'(o_busy), 0);

        // 1: delays {1,2,3,4}, triggers at 3, 7, 12, 18
        for (int i = 0; i < NS; i++) do_cycle(0, 0, 0, 1, i, i + 1);
        clear_q();
        t0 = cyc;
        for (int r = 0; r <= 24; r++) begin
            do_cycle(r == 0, (r == 3 || r == 7 || r == 12 || r == 18), 0, 0, 0, 0);
            if (r == 22) chk("t1_busy_at22", 32'(o_busy), 1);
            if (r == 23) chk("t1_busy_at23", 32'(o_busy), 0);
        end
        chk("t1_npulse", pq.size(), 4);
        for (int i = 0; i < 4; i++) chk("t1_pulse_cycle", qget(pq, i), e1[i]);
        chk("t1_ndone", dq.size(), 1);
        chk("t1_done_cycle", qget(dq, 0), 22);

        // 2: no trigger -> watchdog fires at cycle 8
        clear_q();
        t0 = cyc;
        for (int r = 0; r <= 11; r++) begin
            do_cycle(r == 0, 0, 0, 0, 0, 0);
            if (r == 9) chk("t2_busy_at9", 32'(o_busy), 0);
        end
        chk("t2_nto", tq.size(), 1);
        chk("t2_to_cycle", qget(tq, 0), 8);
        chk("t2_npulse", pq.size(), 0);

        // 3: trigger exactly in the timeout cycle wins
        clear_q();
        t0 = cyc;
        for (int r = 0; r <= 10; r++) do_cycle(r == 0, r == 8, r == 10, 0, 0, 0);
        chk("t3_nto", tq.size(), 0);
        chk("t3_npulse", pq.size(), 1);
        chk("t3_pulse_cycle", qget(pq, 0), 9);

        // 4: abort during a long delay, then a clean run
        do_cycle(0, 0, 0, 1, 0, 5);
        clear_q();
        t0 = cyc;
        for (int r = 0; r <= 12; r++) begin
            do_cycle(r == 0, r == 2, r == 5, 0, 0, 0);
            if (r == 6) chk("t4_busy_at6", 32'(o_busy), 0);
        end
        chk("t4_npulse_aborted", pq.size(), 0);
        clear_q();
        t0 = cyc;
        for (int r = 0; r <= 9; r++) do_cycle(r == 0, r == 2, r == 9, 0, 0, 0);
        chk("t4_rerun_pulse", qget(pq, 0), 7);

        // 5: write while busy is dropped; stored 0 behaves as 1
        do_cycle(0, 0, 0, 1, 1, 3);
        clear_q();
        t0 = cyc;
        for (int r = 0; r <= 14; r++) do_cycle(r == 0, (r == 2 || r == 9), r == 14, r == 3, 1, 9);
        chk("t5_npulse", pq.size(), 2);
        chk("t5_pulse0", qget(pq, 0), 7);
        chk("t5_pulse1_old_delay", qget(pq, 1), 12);
        do_cycle(0, 0, 0, 1, 0, 0);
        clear_q();
        t0 = cyc;
        for (int r = 0; r <= 5; r++) do_cycle(r == 0, r == 2, r == 5, 0, 0, 0);
        chk("t5_zero_delay_pulse", qget(pq, 0), 3);

        // 6: reset in DELAY restores the table
        do_cycle(0, 0, 0, 1, 0, 1);
        do_cycle(0, 0, 0, 1, 1, 1);
        do_cycle(0, 0, 0, 1, 2, 6);
        clear_q();
        t0 = cyc;
        for (int r = 0; r <= 7; r++) do_cycle(r == 0, (r == 1 || r == 3 || r == 5), 0, 0, 0, 0);
        chk("t6_pre_pulses", pq.size(), 2);
        do_reset(1);
        do_cycle(0, 0, 0, 0, 0, 0);
        chk("t6_busy_after_rst", 32'(o_busy), 0);
        chk("t6_pulse_after_rst", 32'(o_pulse), 0);
        clear_q();
        t0 = cyc;
        for (int r = 0; r <= 8; r++) do_cycle(r == 0, (r == 1 || r == 3 || r == 5), r == 8, 0, 0, 0);
        chk("t6_step2_pulse", qget(pq, 2), 6);

        // randomized traffic against the model
        for (int r = 0; r < 600; r++) begin
            do_cycle($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0,
                     int'($urandom_range(0, NS - 1)), int'($urandom_range(0, 4)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
